mppt_po_controller: RTL and testbench

Perturb-and-observe maximum-power-point-tracking controller that sequences the renewable-energy converter datapath.
- Requests a voltage/current sample from the measurement front end and computes power.
- Compares that power with the previous sample and steps the converter duty cycle toward maximum power.
- Sits between the ADC/measurement interface and the PWM/converter stage inside tt_um_vedm_industries.

---
 rtl/mppt_pkg.sv | 25 ++
 rtl/duty_stepper.sv | 36 +++
 rtl/mppt_po_controller.sv | 179 +++++++++++++++++
 tb/tb_mppt_po_controller.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mppt_pkg.sv
// Shared types and widths for the perturb-and-observe MPPT controller.
package mppt_pkg;

  localparam int unsigned SAMPLE_W = 8;
  localparam int unsigned POWER_W  = 16;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StCalc,
    StDecide,
    StSettle
  } state_e;

  // Bits needed for a counter running 0 .. max(a, b)-1.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

  // Width for the default SETTLE_CYC=64 / TIMEOUT_CYC=255 configuration.
  localparam int unsigned CNT_W_DEFAULT = cnt_width(64, 255);

endpackage

// File: rtl/duty_stepper.sv
// Combinational duty perturbation: duty +/- STEP with clamp to [DUTY_MIN, DUTY_MAX].
module duty_stepper #(
  parameter int unsigned DUTY_W   = 8,
  parameter int unsigned STEP     = 4,
  parameter int unsigned DUTY_MIN = 16,
  parameter int unsigned DUTY_MAX = 240
) (
  input  logic [DUTY_W-1:0] duty_i,
  input  logic              dir_i,
  output logic [DUTY_W-1:0] duty_o,
  output logic              clamp_hit_o
);

  localparam logic [DUTY_W:0] StepW = (DUTY_W + 1)'(STEP);
  localparam logic [DUTY_W:0] MinW  = (DUTY_W + 1)'(DUTY_MIN);
  localparam logic [DUTY_W:0] MaxW  = (DUTY_W + 1)'(DUTY_MAX);

  logic [DUTY_W:0] cand;
  logic            borrow;

  // Candidate at one extra bit; the top bit flags overflow (up) or borrow (down).
  always_comb begin
    cand        = dir_i ? ({1'b0, duty_i} + StepW) : ({1'b0, duty_i} - StepW);
    borrow      = ~dir_i & cand[DUTY_W];
    duty_o      = cand[DUTY_W-1:0];
    clamp_hit_o = 1'b0;
    if (borrow || (cand < MinW)) begin
      duty_o      = MinW[DUTY_W-1:0];
      clamp_hit_o = 1'b1;
    end else if (cand > MaxW) begin
      duty_o      = MaxW[DUTY_W-1:0];
      clamp_hit_o = 1'b1;
    end
  end

endmodule

// File: rtl/mppt_po_controller.sv
// Perturb-and-observe MPPT controller: samples V/I, computes power, steps duty toward max power.
module mppt_po_controller
  import mppt_pkg::*;
#(
  parameter int unsigned DUTY_W      = 8,
  parameter int unsigned DUTY_INIT   = 128,
  parameter int unsigned STEP        = 4,
  parameter int unsigned DUTY_MIN    = 16,
  parameter int unsigned DUTY_MAX    = 240,
  parameter int unsigned SETTLE_CYC  = 64,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  output logic                sample_req,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] v_in,
  input  logic [SAMPLE_W-1:0] i_in,
  output logic [DUTY_W-1:0]   duty,
  output logic                duty_valid,
  output logic [POWER_W-1:0]  power,
  output logic                dir,
  output logic                fault,
  output logic                busy
);

  localparam int unsigned    CntW        = cnt_width(SETTLE_CYC, TIMEOUT_CYC);
  localparam logic [CntW-1:0] SettleLast  = CntW'(SETTLE_CYC - 1);
  localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT_CYC - 1);
  localparam logic [DUTY_W-1:0] DutyMinW  = DUTY_W'(DUTY_MIN);

  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [SAMPLE_W-1:0]  v_q, v_d, i_q, i_d;
  logic [POWER_W-1:0]   p_now_q, p_now_d;
  // power_q doubles as p_prev: both are loaded with p_now in the same cycle.
  logic [POWER_W-1:0]   power_q, power_d;
  logic [DUTY_W-1:0]    duty_q, duty_d;
  logic                 dir_q, dir_d;
  logic                 sample_req_q, sample_req_d;
  logic                 duty_valid_q, duty_valid_d;
  logic                 fault_q, fault_d;
  logic                 busy_q, busy_d;

  logic                 dir_new;
  logic [DUTY_W-1:0]    step_duty;
  logic                 clamp_hit;

  // Direction before clamping: reverse when power dropped, hold otherwise.
  always_comb begin
    dir_new = (p_now_q < power_q) ? ~dir_q : dir_q;
  end

  duty_stepper #(
    .DUTY_W   (DUTY_W),
    .STEP     (STEP),
    .DUTY_MIN (DUTY_MIN),
    .DUTY_MAX (DUTY_MAX)
  ) u_duty_stepper (
    .duty_i      (duty_q),
    .dir_i       (dir_new),
    .duty_o      (step_duty),
    .clamp_hit_o (clamp_hit)
  );

  // Next-state logic for the FSM, counters, datapath registers and outputs.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    v_d          = v_q;
    i_d          = i_q;
    p_now_d      = p_now_q;
    power_d      = power_q;
    duty_d       = duty_q;
    dir_d        = dir_q;
    fault_d      = fault_q;
    duty_valid_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (en) begin
          state_d = StReq;
          cnt_d   = '0;
          fault_d = 1'b0;
        end
      end
      StReq: begin
        if (!en) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (sample_valid) begin
          // A valid sample on the timeout cycle still counts as a capture.
          v_d     = v_in;
          i_d     = i_in;
          state_d = StCalc;
          cnt_d   = '0;
        end else if (cnt_q == TimeoutLast) begin
          fault_d = 1'b1;
          state_d = StSettle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StCalc: begin
        p_now_d = POWER_W'(v_q) * POWER_W'(i_q);
        state_d = StDecide;
      end
      StDecide: begin
        duty_d       = step_duty;
        // On a clamp, point away from whichever bound was hit.
        dir_d        = clamp_hit ? (step_duty == DutyMinW) : dir_new;
        power_d      = p_now_q;
        duty_valid_d = 1'b1;
        state_d      = StSettle;
        cnt_d        = '0;
      end
      StSettle: begin
        if (!en) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q == SettleLast) begin
          state_d = StReq;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase

    sample_req_d = (state_d == StReq);
    busy_d       = (state_d != StIdle);
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      v_q          <= '0;
      i_q          <= '0;
      p_now_q      <= '0;
      power_q      <= '0;
      duty_q       <= DUTY_W'(DUTY_INIT);
      dir_q        <= 1'b1;
      sample_req_q <= 1'b0;
      duty_valid_q <= 1'b0;
      fault_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      v_q          <= v_d;
      i_q          <= i_d;
      p_now_q      <= p_now_d;
      power_q      <= power_d;
      duty_q       <= duty_d;
      dir_q        <= dir_d;
      sample_req_q <= sample_req_d;
      duty_valid_q <= duty_valid_d;
      fault_q      <= fault_d;
      busy_q       <= busy_d;
    end
  end

  assign sample_req = sample_req_q;
  assign duty       = duty_q;
  assign duty_valid = duty_valid_q;
  assign power      = power_q;
  assign dir        = dir_q;
  assign fault      = fault_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_mppt_po_controller.sv
// Directed bench for mppt_po_controller: table-driven P&O steps plus timeout/abort/reset sequences.
module tb_mppt_po_controller;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        en1 = 1'b0, en2 = 1'b0;
  logic        sel = 1'b0;
  logic        drv_valid = 1'b0;
  logic [7:0]  drv_v = '0, drv_i = '0;

  logic        req1, req2, dv1, dv2, dir1, dir2, fault1, fault2, busy1, busy2;
  logic [7:0]  duty1, duty2;
  logic [15:0] power1, power2;
  logic        valid1, valid2;

  assign valid1 = sel ? 1'b0 : drv_valid;
  assign valid2 = sel ? drv_valid : 1'b0;

  logic        cur_req, cur_dv, cur_dir;
  logic [7:0]  cur_duty;
  logic [15:0] cur_power;
  assign cur_req   = sel ? req2 : req1;
  assign cur_dv    = sel ? dv2 : dv1;
  assign cur_dir   = sel ? dir2 : dir1;
  assign cur_duty  = sel ? duty2 : duty1;
  assign cur_power = sel ? power2 : power1;

  mppt_po_controller #(
    .SETTLE_CYC  (8),
    .TIMEOUT_CYC (20)
  ) dut1 (
    .clk          (clk),
    .rst          (rst),
    .en           (en1),
    .sample_req   (req1),
    .sample_valid (valid1),
    .v_in         (drv_v),
    .i_in         (drv_i),
    .duty         (duty1),
    .duty_valid   (dv1),
    .power        (power1),
    .dir          (dir1),
    .fault        (fault1),
    .busy         (busy1)
  );

  mppt_po_controller #(
    .DUTY_INIT   (238),
    .SETTLE_CYC  (8),
    .TIMEOUT_CYC (20)
  ) dut2 (
    .clk          (clk),
    .rst          (rst),
    .en           (en2),
    .sample_req   (req2),
    .sample_valid (valid2),
    .v_in         (drv_v),
    .i_in         (drv_i),
    .duty         (duty2),
    .duty_valid   (dv2),
    .power        (power2),
    .dir          (dir2),
    .fault        (fault2),
    .busy         (busy2)
  );

  typedef struct {
    logic [7:0]  v;
    logic [7:0]  i;
    logic [15:0] p;
    logic [7:0]  d;
    logic        dir;
  } vec_t;

  vec_t tbl1[4];
  vec_t tbl2[3];

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Wait for a request, present one sample, and check the resulting update.
  task automatic run_vec(input string tag, input vec_t t);
    int w;
    w = 0;
    while (!cur_req && w < 60) begin
      @(negedge clk);
      w++;
    end
    chk({tag, " req_seen"}, cur_req, 1);
    drv_valid = 1'b1;
    drv_v     = t.v;
    drv_i     = t.i;
    @(negedge clk);
    drv_valid = 1'b0;
    chk({tag, " req_drop"}, cur_req, 0);
    chk({tag, " dv_e1"}, cur_dv, 0);
    @(negedge clk);
    chk({tag, " dv_e2"}, cur_dv, 0);
    @(negedge clk);
    chk({tag, " dv_pulse"}, cur_dv, 1);
    chk({tag, " power"}, cur_power, t.p);
    chk({tag, " duty"}, cur_duty, t.d);
    chk({tag, " dir"}, cur_dir, t.dir);
  endtask

  // Count cycles from the duty_valid pulse to the next request, checking the pulse is single.
  task automatic req_latency(input string tag);
    int lat;
    lat = 0;
    @(negedge clk);
    lat++;
    chk({tag, " dv_single"}, cur_dv, 0);
    while (!cur_req && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, " req_latency"}, lat, 8);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic seen_dv;
    tbl1[0] = '{v: 8'd25, i: 8'd10, p: 16'd250, d: 8'd132, dir: 1'b1};
    tbl1[1] = '{v: 8'd25, i: 8'd12, p: 16'd300, d: 8'd136, dir: 1'b1};
    tbl1[2] = '{v: 8'd20, i: 8'd10, p: 16'd200, d: 8'd132, dir: 1'b0};
    tbl1[3] = '{v: 8'd20, i: 8'd10, p: 16'd200, d: 8'd128, dir: 1'b0};
    // Starting at 238: first step clamps at 240 and turns down; later steps keep going down.
    tbl2[0] = '{v: 8'd10, i: 8'd10, p: 16'd100, d: 8'd240, dir: 1'b0};
    tbl2[1] = '{v: 8'd10, i: 8'd20, p: 16'd200, d: 8'd236, dir: 1'b0};
    tbl2[2] = '{v: 8'd10, i: 8'd30, p: 16'd300, d: 8'd232, dir: 1'b0};

    // Reset
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst duty", duty1, 128);
    chk("rst dir", dir1, 1);
    chk("rst power", power1, 0);
    chk("rst req", req1, 0);
    chk("rst busy", busy1, 0);
    chk("rst fault", fault1, 0);
    chk("rst dv", dv1, 0);
    chk("rst duty2", duty2, 238);

    // Tracking steps on dut1
    sel = 1'b0;
    en1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      run_vec($sformatf("step%0d", k), tbl1[k]);
      req_latency($sformatf("step%0d", k));
    end

    // Timeout: now in the first REQ cycle with no valid ever given
    seen_dv = 1'b0;
    for (int k = 1; k <= 19; k++) begin
      @(negedge clk);
      seen_dv |= dv1;
    end
    chk("to fault_before", fault1, 0);
    chk("to req_before", req1, 1);
    @(negedge clk);
    chk("to fault_set", fault1, 1);
    chk("to req_drop", req1, 0);
    chk("to busy", busy1, 1);
    repeat (7) begin
      @(negedge clk);
      seen_dv |= dv1;
    end
    chk("to fault_settle", fault1, 1);
    chk("to no_dv", seen_dv, 0);
    chk("to duty_held", duty1, 128);
    chk("to power_held", power1, 200);
    chk("to dir_held", dir1, 0);
    @(negedge clk);
    chk("to req_again", req1, 1);
    chk("to fault_kept", fault1, 1);
    en1 = 1'b0;
    @(negedge clk);
    chk("to idle_req", req1, 0);
    chk("to idle_busy", busy1, 0);
    chk("to idle_fault", fault1, 1);
    en1 = 1'b1;
    @(negedge clk);
    chk("to fault_clr", fault1, 0);
    chk("to req_reentry", req1, 1);

    // Abort in SETTLE: equal power holds dir=0, duty 128 -> 124
    run_vec("abort", '{v: 8'd20, i: 8'd10, p: 16'd200, d: 8'd124, dir: 1'b0});
    @(negedge clk);
    en1 = 1'b0;
    @(negedge clk);
    chk("abort busy", busy1, 0);
    chk("abort req", req1, 0);
    chk("abort duty", duty1, 124);
    repeat (3) @(negedge clk);
    chk("abort held", duty1, 124);
    chk("abort req_idle", req1, 0);

    // Reset during REQ with a valid sample present
    en1 = 1'b1;
    @(negedge clk);
    chk("rreq req", req1, 1);
    rst       = 1'b1;
    drv_valid = 1'b1;
    drv_v     = 8'd255;
    drv_i     = 8'd255;
    @(negedge clk);
    chk("rreq duty", duty1, 128);
    chk("rreq dir", dir1, 1);
    chk("rreq power", power1, 0);
    chk("rreq req0", req1, 0);
    chk("rreq busy", busy1, 0);
    rst       = 1'b0;
    drv_valid = 1'b0;
    en1       = 1'b0;
    repeat (4) @(negedge clk);
    chk("rreq no_capture", power1, 0);
    chk("rreq still_idle", busy1, 0);

    // Clamp on dut2
    sel = 1'b1;
    en2 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      run_vec($sformatf("clamp%0d", k), tbl2[k]);
      req_latency($sformatf("clamp%0d", k));
    end
    en2 = 1'b0;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
